// File: rtl/ksk_mgr_rd_cmd_gen_if.sv
// Request / node command bus between the key_switch scheduler, the read command generator and the first ksk_mgr node.
// slave = command generator side, master = scheduler/consumer side.
interface ksk_mgr_rd_cmd_gen_if #(
    parameter int KSK_SLOT_W = 2,
    parameter int LINE_NB_W  = 4,
    parameter int NODE_CMD_W = 10
);
    logic                  req_vld;
    logic                  req_rdy;
    logic [KSK_SLOT_W-1:0] req_slot;
    logic [LINE_NB_W-1:0]  req_line_nb;
    logic [NODE_CMD_W-1:0] node_cmd;
    logic                  out_vld;
    logic                  out_rdy;
    logic                  rd_done;
    logic                  req_err;

    modport slave (
        input  req_vld, req_slot, req_line_nb, out_rdy,
        output req_rdy, node_cmd, out_vld, rd_done, req_err
    );

    modport master (
        output req_vld, req_slot, req_line_nb, out_rdy,
        input  req_rdy, node_cmd, out_vld, rd_done, req_err
    );
endinterface

// File: rtl/ksk_mgr_rd_cmd_gen.sv
// KSK read command generator: turns a slot read request into the node_cmd_t stream (reads, buffer fills, shifts).
// Latency: first read 1 cycle after accept, buf_in_avail RAM_LATENCY cycles after each read, rd_done with final shift.
// Backpressure: credit based, reads stall while occ+inflight reaches BUF_DEPTH. Optional KSK_RD_CMD_PERF_CNT_EN adds perf_rd_cnt.
module ksk_mgr_rd_cmd_gen #(
    parameter int RAM_LATENCY      = 2,
    parameter int BUF_DEPTH        = 4,
    parameter int KSK_SLOT_NB      = 3,
    parameter int KS_BLOCK_LINE_NB = 8,
    parameter int KS_LG_NB         = 3,
    parameter int KSK_SLOT_DEPTH   = KS_BLOCK_LINE_NB * KS_LG_NB,
    parameter int KSK_RAM_ADD_W    = $clog2(KSK_SLOT_NB * KSK_SLOT_DEPTH),
    parameter int KSK_SLOT_W       = $clog2(KSK_SLOT_NB + 1),
    parameter int LINE_NB_W        = $clog2(KS_BLOCK_LINE_NB + 1),
    parameter int NODE_CMD_W       = KSK_RAM_ADD_W + 3
) (
    input  logic                       clk,
    input  logic                       s_rst_n,
    ksk_mgr_rd_cmd_gen_if.slave        cmd_if
`ifdef KSK_RD_CMD_PERF_CNT_EN
    ,
    output logic [31:0]                perf_rd_cnt
`endif
);
    localparam int CNT_W = $clog2(KSK_SLOT_DEPTH + 1);
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int SUM_W = $clog2(BUF_DEPTH + RAM_LATENCY + 1) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    typedef struct packed {
        logic                     ram_rd_en;
        logic [KSK_RAM_ADD_W-1:0] ram_rd_add;
        logic                     buf_in_avail;
        logic                     buf_shift;
    } node_cmd_t;

    state_t                   r_state;
    logic                     r_req_rdy;
    logic                     r_req_err;
    logic                     r_rd_done;
    logic [KSK_RAM_ADD_W-1:0] r_base;
    logic [CNT_W-1:0]         r_total;
    logic [CNT_W-1:0]         r_issued;
    logic [CNT_W-1:0]         r_shifted;
    logic [RAM_LATENCY-1:0]   r_pipe;
    logic [OCC_W-1:0]         r_occ;
    node_cmd_t                r_cmd;

    logic                     w_out_vld;
    logic                     w_shift;
    logic                     w_avail;
    logic [SUM_W-1:0]         w_inflight;
    logic [SUM_W-1:0]         w_credit_used;
    logic                     w_issue;
    logic                     w_last_issue;
    logic                     w_last_shift;
    logic                     w_req_ok;
    logic                     w_accept;
    logic [KSK_RAM_ADD_W-1:0] w_rd_add;

    assign w_out_vld = (r_occ != '0);
    assign w_shift   = w_out_vld & cmd_if.out_rdy;
    assign w_avail   = r_pipe[RAM_LATENCY-1];

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RAM_LATENCY; i++) begin
            w_inflight = w_inflight + SUM_W'(r_pipe[i]);
        end
    end

    // Credits come from registered counts only, so a shift frees its slot one cycle later.
    assign w_credit_used = SUM_W'(r_occ) + w_inflight;
    assign w_issue       = (r_state == RUN) && (r_issued != r_total) &&
                           (w_credit_used < SUM_W'(BUF_DEPTH));
    assign w_last_issue  = ((r_issued + CNT_W'(1)) == r_total);
    assign w_last_shift  = w_shift && ((r_shifted + CNT_W'(1)) == r_total);
    assign w_rd_add      = r_base + KSK_RAM_ADD_W'(r_issued);

    assign w_req_ok = (cmd_if.req_slot < KSK_SLOT_W'(KSK_SLOT_NB)) &&
                      (cmd_if.req_line_nb != '0) &&
                      (cmd_if.req_line_nb <= LINE_NB_W'(KS_BLOCK_LINE_NB));
    assign w_accept = r_req_rdy & cmd_if.req_vld;

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state   <= IDLE;
            r_req_rdy <= 1'b0;
            r_req_err <= 1'b0;
            r_rd_done <= 1'b0;
            r_base    <= '0;
            r_total   <= '0;
            r_issued  <= '0;
            r_shifted <= '0;
            r_pipe    <= '0;
            r_occ     <= '0;
            r_cmd     <= '0;
        end else begin
            r_req_err <= 1'b0;
            r_rd_done <= 1'b0;

            r_cmd.ram_rd_en    <= w_issue;
            r_cmd.ram_rd_add   <= w_issue ? w_rd_add : '0;
            r_cmd.buf_in_avail <= w_avail;
            r_cmd.buf_shift    <= w_shift;

            // Stage 0 mirrors the ram_rd_en just registered; the last stage becomes buf_in_avail.
            r_pipe <= (r_pipe << 1) | RAM_LATENCY'(w_issue);
            r_occ  <= r_occ + OCC_W'(w_avail) - OCC_W'(w_shift);

            if (w_issue) r_issued  <= r_issued + CNT_W'(1);
            if (w_shift) r_shifted <= r_shifted + CNT_W'(1);

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_req_ok) begin
                            r_base    <= KSK_RAM_ADD_W'(cmd_if.req_slot) * KSK_RAM_ADD_W'(KSK_SLOT_DEPTH);
                            r_total   <= CNT_W'(cmd_if.req_line_nb) * CNT_W'(KS_LG_NB);
                            r_issued  <= '0;
                            r_shifted <= '0;
                            r_req_rdy <= 1'b0;
                            r_state   <= RUN;
                        end else begin
                            r_req_err <= 1'b1;
                        end
                    end else begin
                        r_req_rdy <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_issue && w_last_issue) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (w_last_shift) begin
                        r_rd_done <= 1'b1;
                        r_req_rdy <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_if.req_rdy  = r_req_rdy;
    assign cmd_if.node_cmd = r_cmd;
    assign cmd_if.out_vld  = w_out_vld;
    assign cmd_if.rd_done  = r_rd_done;
    assign cmd_if.req_err  = r_req_err;

`ifdef KSK_RD_CMD_PERF_CNT_EN
    logic [31:0] r_perf_rd_cnt;

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_perf_rd_cnt <= '0;
        end else if (w_issue && (r_perf_rd_cnt != 32'hFFFF_FFFF)) begin
            r_perf_rd_cnt <= r_perf_rd_cnt + 32'd1;
        end
    end

    assign perf_rd_cnt = r_perf_rd_cnt;
`endif
endmodule

// File: tb/tb_ksk_mgr_rd_cmd_gen.sv
// Directed bench for ksk_mgr_rd_cmd_gen: address/total scoreboard plus a cycle monitor of the node command stream.
// node_cmd layout: {ram_rd_en, ram_rd_add[6:0], buf_in_avail, buf_shift}.
module tb_ksk_mgr_rd_cmd_gen;
    localparam int SLOT_W = 2;
    localparam int LINE_W = 4;
    localparam int ADD_W  = 7;
    localparam int CMD_W  = 10;

    logic clk = 1'b0;
    logic s_rst_n = 1'b0;
    always #5 clk = ~clk;

    ksk_mgr_rd_cmd_gen_if #(.KSK_SLOT_W(SLOT_W), .LINE_NB_W(LINE_W), .NODE_CMD_W(CMD_W)) cmd_if ();

`ifdef KSK_RD_CMD_PERF_CNT_EN
    logic [31:0] perf_rd_cnt;
`endif

    ksk_mgr_rd_cmd_gen dut (
        .clk         (clk),
        .s_rst_n     (s_rst_n),
        .cmd_if      (cmd_if)
`ifdef KSK_RD_CMD_PERF_CNT_EN
        ,
        .perf_rd_cnt (perf_rd_cnt)
`endif
    );

    typedef struct {
        logic [ADD_W-1:0] addr;
        bit               first;
        int               acc;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      tot_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_occ = 0, m_infl = 0, sh_cnt = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0, avail_cnt = 0;
    int done_cyc = 0, first_rd_cyc = 0, last_rd_cyc = 0, last_acc = 0;
    bit [1:0] en_hist = '0;
    bit prev_take = 1'b0;
    logic m_en, m_av, m_sh;
    logic [ADD_W-1:0] m_ad;
    rd_exp_t m_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Monitor: independent occupancy / latency model built from the observed command words.
    always @(negedge clk) begin
        if (!s_rst_n) begin
            en_hist   = '0;
            m_occ     = 0;
            m_infl    = 0;
            sh_cnt    = 0;
            prev_take = 1'b0;
        end else begin
            m_en = cmd_if.node_cmd[CMD_W-1];
            m_ad = cmd_if.node_cmd[CMD_W-2:2];
            m_av = cmd_if.node_cmd[1];
            m_sh = cmd_if.node_cmd[0];
            if (m_en) begin
                rd_cnt++;
                last_rd_cyc = cyc;
                if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    m_e = rd_q.pop_front();
                    chk("rd_addr", m_ad, m_e.addr);
                    if (m_e.first) begin
                        first_rd_cyc = cyc;
                        chk("rd_first_lat", cyc - m_e.acc, 1);
                    end
                end
            end
            chk("avail_lat", m_av, en_hist[1]);
            chk("shift_gate", m_sh, prev_take);
            m_infl = m_infl + int'(m_en) - int'(m_av);
            m_occ  = m_occ + int'(m_av) - int'(m_sh);
            if (m_av) avail_cnt++;
            chk("out_vld", cmd_if.out_vld, m_occ > 0);
            chk("credit", (m_occ + m_infl) <= 4, 1);
            if (m_sh) sh_cnt++;
            if (cmd_if.rd_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_with_shift", m_sh, 1);
                if (tot_q.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_count", sh_cnt, tot_q.pop_front());
                sh_cnt = 0;
            end
            if (cmd_if.req_err) err_cnt++;
            en_hist   = {en_hist[0], m_en};
            prev_take = cmd_if.out_vld & cmd_if.out_rdy;
        end
    end

    task automatic send_req(input int slot, input int line, input bit ok);
        int acc;
        int n = 0;
        @(negedge clk);
        cmd_if.req_vld     = 1'b1;
        cmd_if.req_slot    = SLOT_W'(slot);
        cmd_if.req_line_nb = LINE_W'(line);
        while (!cmd_if.req_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_if.req_rdy) chk("req_rdy_timeout", 0, 1);
        acc = cyc + 1;
        last_acc = acc;
        if (ok) begin
            for (int i = 0; i < line * 3; i++)
                rd_q.push_back('{addr: ADD_W'(slot * 24 + i), first: (i == 0), acc: acc});
            tot_q.push_back(line * 3);
        end
        @(posedge clk);
        #1 cmd_if.req_vld = 1'b0;
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_timeout", done_cnt != d0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, e0, av0, n;
        int bad_s[3];
        int bad_l[3];
        bad_s = '{3, 0, 2};
        bad_l = '{1, 0, 9};
        cmd_if.req_vld     = 1'b0;
        cmd_if.req_slot    = '0;
        cmd_if.req_line_nb = '0;
        cmd_if.out_rdy     = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_req_rdy", cmd_if.req_rdy, 0);
        chk("rst_node_cmd", cmd_if.node_cmd, 0);
        chk("rst_out_vld", cmd_if.out_vld, 0);
        chk("rst_rd_done", cmd_if.rd_done, 0);
        chk("rst_req_err", cmd_if.req_err, 0);
`ifdef KSK_RD_CMD_PERF_CNT_EN
        chk("rst_perf", perf_rd_cnt, 0);
`endif
        s_rst_n = 1'b1;
        #1 chk("rdy_before_edge", cmd_if.req_rdy, 0);
        @(negedge clk);
        chk("rdy_after_edge", cmd_if.req_rdy, 1);

        // Slot 1, two lines, full-rate consumer: addresses 24..29 back to back.
        for (int r = 0; r < 2; r++) begin
            send_req(1, 2, 1);
            chk("s1_rdy_low", cmd_if.req_rdy, 0);
            wait_done();
            chk("s1_burst", last_rd_cyc - first_rd_cyc, 5);
        end
`ifdef KSK_RD_CMD_PERF_CNT_EN
        chk("perf_cnt", perf_rd_cnt, 12);
`endif

        // Stalled consumer: credits cap the reads at the buffer depth.
        @(posedge clk);
        #1 cmd_if.out_rdy = 1'b0;
        rd0 = rd_cnt;
        send_req(0, 8, 1);
        repeat (15) @(negedge clk);
        #1;
        chk("s2_stall_reads", rd_cnt - rd0, 4);
        chk("s2_out_vld", cmd_if.out_vld, 1);
        chk("s2_occ", m_occ, 4);
        @(posedge clk);
        #1 cmd_if.out_rdy = 1'b1;
        wait_done();
        chk("s2_total_reads", rd_cnt - rd0, 24);

        // Rejected requests.
        e0  = err_cnt;
        rd0 = rd_cnt;
        for (int k = 0; k < 3; k++) begin
            send_req(bad_s[k], bad_l[k], 0);
            @(negedge clk);
            chk("err_pulse", cmd_if.req_err, 1);
            chk("err_rdy", cmd_if.req_rdy, 1);
            @(negedge clk);
            chk("err_clear", cmd_if.req_err, 0);
        end
        #1;
        chk("err_count", err_cnt - e0, 3);
        chk("err_no_reads", rd_cnt - rd0, 0);

        // Reset in the middle of a run.
        rd0 = rd_cnt;
        send_req(2, 2, 1);
        n = 0;
        while ((rd_cnt - rd0) < 3 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("s4_reads_seen", (rd_cnt - rd0) >= 3, 1);
        #2 s_rst_n = 1'b0;
        rd_q.delete();
        tot_q.delete();
        #1;
        chk("s4_node_cmd", cmd_if.node_cmd, 0);
        chk("s4_out_vld", cmd_if.out_vld, 0);
        chk("s4_req_rdy", cmd_if.req_rdy, 0);
        chk("s4_rd_done", cmd_if.rd_done, 0);
        repeat (2) @(negedge clk);
        s_rst_n = 1'b1;
        av0 = avail_cnt;
        repeat (6) @(negedge clk);
        #1;
        chk("s4_no_avail", avail_cnt - av0, 0);
        send_req(0, 1, 1);
        wait_done();

        // Back-to-back requests: second accepted right after the first rd_done.
        send_req(0, 1, 1);
        send_req(1, 1, 1);
        chk("b2b_accept", last_acc, done_cyc + 1);
        wait_done();

        repeat (5) @(negedge clk);
        #1;
        chk("rd_q_empty", rd_q.size(), 0);
        chk("tot_q_empty", tot_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
